// File: rtl/tl_rx_credit_ctrl.sv
// Receive-side TL flow control: tracks allocated/received credits per class, flags receiver
// overflow and schedules UpdateFC DLLPs (threshold- or timer-driven, round-robin across classes).
module tl_rx_credit_ctrl #(
  parameter int unsigned PH_INIT    = 32,
  parameter int unsigned PD_INIT    = 256,
  parameter int unsigned NH_INIT    = 32,
  parameter int unsigned CH_INIT    = 0,
  parameter int unsigned CD_INIT    = 0,
  parameter int unsigned UPD_THRESH = 8,
  parameter int unsigned UPD_PERIOD = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        link_active_i,
  input  logic        rx_tlp_valid_i,
  input  logic [1:0]  rx_tlp_type_i,
  input  logic [9:0]  rx_tlp_len_i,
  input  logic        rx_tlp_has_data_i,
  input  logic        p_hdr_rden_i,
  input  logic        p_data_rden_i,
  input  logic        np_hdr_rden_i,
  input  logic        cpl_hdr_rden_i,
  input  logic        cpl_data_rden_i,
  output logic [11:0] init_ph_o,
  output logic [11:0] init_pd_o,
  output logic [11:0] init_nh_o,
  output logic [11:0] init_ch_o,
  output logic [11:0] init_cd_o,
  output logic        updatefc_req_o,
  output logic [1:0]  updatefc_type_o,
  output logic [11:0] updatefc_hdr_o,
  output logic [11:0] updatefc_data_o,
  input  logic        updatefc_ack_i,
  output logic        overflow_err_o,
  output logic [1:0]  overflow_type_o
);
  typedef enum logic {S_IDLE, S_SEND} state_t;

  localparam int unsigned NCNT = 5;
  localparam int unsigned TW   = (UPD_PERIOD > 1) ? $clog2(UPD_PERIOD) : 1;
  // Counter order: PH, PD, NH, CH, CD; each maps to a class and a hdr/data field.
  localparam logic [11:0] INIT_V  [NCNT] = '{12'(PH_INIT), 12'(PD_INIT), 12'(NH_INIT),
                                            12'(CH_INIT), 12'(CD_INIT)};
  localparam logic [1:0]  CLS     [NCNT] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
  localparam logic        IS_DATA [NCNT] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  state_t      state_q, state_d;
  logic [11:0] ca_q [NCNT], ca_d [NCNT];
  logic [11:0] cr_q [NCNT], cr_d [NCNT];
  logic [11:0] adv_q[NCNT], adv_d[NCNT];
  logic [11:0] inc  [NCNT];
  logic [11:0] need [NCNT];
  logic [11:0] delta[NCNT];
  logic [2:0]  pending_q, pending_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  snap_type_q, snap_type_d;
  logic [11:0] snap_hdr_q, snap_hdr_d;
  logic [11:0] snap_data_q, snap_data_d;
  logic        ovf_err_q, ovf_err_d;
  logic [1:0]  ovf_type_q, ovf_type_d;
  logic [11:0] dneed;
  logic        fail, found;
  logic [1:0]  pick;
  logic [2:0]  due, differ;

  assign inc[0] = p_hdr_rden_i    ? 12'd1 : '0;
  assign inc[1] = p_data_rden_i   ? 12'd2 : '0;
  assign inc[2] = np_hdr_rden_i   ? 12'd1 : '0;
  assign inc[3] = cpl_hdr_rden_i  ? 12'd1 : '0;
  assign inc[4] = cpl_data_rden_i ? 12'd2 : '0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    timer_d     = (timer_q == '0) ? TW'(UPD_PERIOD - 1) : timer_q - TW'(1);
    snap_type_d = snap_type_q;
    snap_hdr_d  = snap_hdr_q;
    snap_data_d = snap_data_q;
    ovf_err_d   = ovf_err_q;
    ovf_type_d  = ovf_type_q;
    fail        = 1'b0;
    found       = 1'b0;
    pick        = last_q;
    due         = '0;
    differ      = '0;
    dneed       = (rx_tlp_len_i == '0) ? 12'd256 : (({2'b00, rx_tlp_len_i} + 12'd3) >> 2);
    for (int unsigned k = 0; k < NCNT; k++) begin
      ca_d[k]  = ca_q[k];
      cr_d[k]  = cr_q[k];
      adv_d[k] = adv_q[k];
      need[k]  = '0;
      delta[k] = ca_q[k] - adv_q[k];
    end

    // Counters with a zero init value are infinite: never checked, tracked or advertised.
    for (int unsigned k = 0; k < NCNT; k++) begin
      if (INIT_V[k] != '0) begin
        if (rx_tlp_type_i == CLS[k])
          need[k] = IS_DATA[k] ? (rx_tlp_has_data_i ? dneed : '0) : 12'd1;
        if ((need[k] != '0) && ((ca_q[k] - cr_q[k] - need[k]) >= 12'd2048))
          fail = 1'b1;
        ca_d[k] = ca_q[k] + inc[k];
        if (delta[k] >= 12'(UPD_THRESH)) due[CLS[k]] = 1'b1;
        if (delta[k] != '0)              differ[CLS[k]] = 1'b1;
      end
    end

    if (rx_tlp_valid_i) begin
      if (fail) begin
        ovf_err_d = 1'b1;
        if (!ovf_err_q) ovf_type_d = rx_tlp_type_i;
      end else begin
        for (int unsigned k = 0; k < NCNT; k++) cr_d[k] = cr_q[k] + need[k];
      end
    end

    pending_d = pending_q | due | ((timer_q == '0) ? differ : '0);

    unique case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          for (int unsigned i = 1; i <= 3; i++) begin
            if (!found && pending_q[(32'(last_q) + i) % 3]) begin
              found = 1'b1;
              pick  = 2'((32'(last_q) + i) % 3);
            end
          end
          snap_type_d = pick;
          snap_hdr_d  = '0;
          snap_data_d = '0;
          for (int unsigned k = 0; k < NCNT; k++) begin
            if (CLS[k] == pick) begin
              if (IS_DATA[k]) snap_data_d = ca_q[k];
              else            snap_hdr_d  = ca_q[k];
            end
          end
          last_d  = pick;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (updatefc_ack_i) begin
          for (int unsigned k = 0; k < NCNT; k++) begin
            if ((CLS[k] == snap_type_q) && (INIT_V[k] != '0))
              adv_d[k] = IS_DATA[k] ? snap_data_q : snap_hdr_q;
          end
          // Clear wins over this cycle's set; a still-due class re-arms next cycle.
          pending_d[snap_type_q] = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!link_active_i) begin
      for (int unsigned k = 0; k < NCNT; k++) begin
        ca_d[k]  = INIT_V[k];
        cr_d[k]  = '0;
        adv_d[k] = INIT_V[k];
      end
      pending_d   = '0;
      timer_d     = TW'(UPD_PERIOD - 1);
      state_d     = S_IDLE;
      last_d      = 2'd2;
      snap_type_d = '0;
      snap_hdr_d  = '0;
      snap_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NCNT; k++) begin
        ca_q[k]  <= INIT_V[k];
        cr_q[k]  <= '0;
        adv_q[k] <= INIT_V[k];
      end
      state_q     <= S_IDLE;
      pending_q   <= '0;
      timer_q     <= TW'(UPD_PERIOD - 1);
      last_q      <= 2'd2;
      snap_type_q <= '0;
      snap_hdr_q  <= '0;
      snap_data_q <= '0;
      ovf_err_q   <= 1'b0;
      ovf_type_q  <= '0;
    end else begin
      for (int unsigned k = 0; k < NCNT; k++) begin
        ca_q[k]  <= ca_d[k];
        cr_q[k]  <= cr_d[k];
        adv_q[k] <= adv_d[k];
      end
      state_q     <= state_d;
      pending_q   <= pending_d;
      timer_q     <= timer_d;
      last_q      <= last_d;
      snap_type_q <= snap_type_d;
      snap_hdr_q  <= snap_hdr_d;
      snap_data_q <= snap_data_d;
      ovf_err_q   <= ovf_err_d;
      ovf_type_q  <= ovf_type_d;
    end
  end

  assign init_ph_o       = INIT_V[0];
  assign init_pd_o       = INIT_V[1];
  assign init_nh_o       = INIT_V[2];
  assign init_ch_o       = INIT_V[3];
  assign init_cd_o       = INIT_V[4];
  assign updatefc_req_o  = (state_q == S_SEND);
  assign updatefc_type_o = snap_type_q;
  assign updatefc_hdr_o  = snap_hdr_q;
  assign updatefc_data_o = snap_data_q;
  assign overflow_err_o  = ovf_err_q;
  assign overflow_type_o = ovf_type_q;
endmodule
